// File: rtl/equal_cnt_rate_mon.sv
// Windowed rate monitor: per-window event count from a wrapping 8-bit counter, sticky threshold alarm.
// Optional peak tracker on peak_o is built only when EQ_RATE_MON_PEAK_EN is defined.
module equal_cnt_rate_mon #(
  parameter int unsigned WINDOW = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] count_i,
  input  logic [7:0] thr_i,
  input  logic       alarm_ack_i,
  output logic [7:0] delta_o,
  output logic       delta_vld_o,
  output logic       alarm_o,
  output logic [7:0] peak_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ALARM
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] delta_q, delta_d;
  logic       vld_q, vld_d;
  logic       alarm_q, alarm_d;
  logic [7:0] diff;
  logic       win_end;

  // Modular subtraction stays correct across the 255->0 wrap of count_i.
  assign diff    = count_i - base_q;
  assign win_end = en_i && (state_q != IDLE) && (win_cnt_q == 8'(WINDOW - 1));

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    win_cnt_d = win_cnt_q;
    delta_d   = delta_q;
    vld_d     = 1'b0;
    alarm_d   = alarm_q;

    if (alarm_ack_i) begin
      alarm_d = 1'b0;
    end

    if (!en_i) begin
      state_d   = IDLE;
      win_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          base_d    = count_i;
          win_cnt_d = '0;
          state_d   = RUN;
        end
        default: begin
          if (alarm_ack_i) begin
            state_d = RUN;
          end
          if (win_end) begin
            delta_d   = diff;
            vld_d     = 1'b1;
            base_d    = count_i;
            win_cnt_d = '0;
            // Alarm set takes priority over a same-edge acknowledge.
            if (diff > thr_i) begin
              alarm_d = 1'b1;
              state_d = ALARM;
            end
          end else begin
            win_cnt_d = win_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      base_q    <= '0;
      win_cnt_q <= '0;
      delta_q   <= '0;
      vld_q     <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      win_cnt_q <= win_cnt_d;
      delta_q   <= delta_d;
      vld_q     <= vld_d;
      alarm_q   <= alarm_d;
    end
  end

`ifdef EQ_RATE_MON_PEAK_EN
  logic [7:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (alarm_ack_i) begin
      peak_d = '0;
    end
    if (win_end && (alarm_ack_i || (diff > peak_q))) begin
      peak_d = diff;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

  assign delta_o     = delta_q;
  assign delta_vld_o = vld_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_equal_cnt_rate_mon.sv
// Scoreboard bench for equal_cnt_rate_mon (WINDOW=16); expected strobes are queued by the stimulus.
module tb_equal_cnt_rate_mon;

`ifdef EQ_RATE_MON_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       en_i = 1'b0;
  logic [7:0] count_i = '0;
  logic [7:0] thr_i = '0;
  logic       alarm_ack_i = 1'b0;
  logic [7:0] delta_o;
  logic       delta_vld_o;
  logic       alarm_o;
  logic [7:0] peak_o;

  typedef struct {
    int unsigned edge_no;
    int unsigned delta;
    int unsigned alarm;
    int unsigned peak;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int unsigned edge_n = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned e0;

  equal_cnt_rate_mon #(.WINDOW(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .count_i    (count_i),
    .thr_i      (thr_i),
    .alarm_ack_i(alarm_ack_i),
    .delta_o    (delta_o),
    .delta_vld_o(delta_vld_o),
    .alarm_o    (alarm_o),
    .peak_o     (peak_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_win(input int unsigned e, input int unsigned d, input int unsigned a,
                            input int unsigned p);
    exp_t x;
    x.edge_no = e;
    x.delta   = d;
    x.alarm   = a;
    x.peak    = PEAK ? p : 0;
    sb.push_back(x);
  endtask

  // Inputs applied here are sampled by the next rising edge; returns 1 time unit after it.
  task automatic drive(input logic en, input logic [7:0] inc, input logic ack);
    en_i        = en;
    count_i     = count_i + inc;
    alarm_ack_i = ack;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_ni && delta_vld_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe edge=%0d actual delta=%0d required no strobe",
                 edge_n, delta_o);
      end else begin
        got = sb.pop_front();
        chk("strobe_edge", edge_n, got.edge_no);
        chk("delta", delta_o, got.delta);
        chk("alarm_at_strobe", alarm_o, got.alarm);
        chk("peak_at_strobe", peak_o, got.peak);
      end
    end
  end

  initial begin
    // Reset state
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_delta", delta_o, 0);
    chk("rst_vld", delta_vld_o, 0);
    chk("rst_alarm", alarm_o, 0);
    chk("rst_peak", peak_o, 0);
    rst_ni = 1'b1;

    // Idle with counter moving: no strobes
    for (int k = 0; k < 50; k++) drive(1'b0, 8'd1, 1'b0);
    chk("idle_delta", delta_o, 0);
    chk("idle_vld", delta_vld_o, 0);

    // Steady rate: one event every other cycle -> 8 per window
    thr_i = 8'd10;
    e0 = edge_n + 1;
    expect_win(e0 + 16, 8, 0, 8);
    expect_win(e0 + 32, 8, 0, 8);
    expect_win(e0 + 48, 8, 0, 8);
    for (int k = 0; k <= 48; k++) drive(1'b1, (k % 2 == 1) ? 8'd1 : 8'd0, 1'b0);
    repeat (3) drive(1'b0, 8'd0, 1'b0);
    chk("steady_alarm", alarm_o, 0);

    // Wrap: 250 -> 10 gives 16, equal to threshold, no alarm
    thr_i   = 8'd16;
    count_i = 8'd250;
    e0 = edge_n + 1;
    expect_win(e0 + 16, 16, 0, 16);
    for (int k = 0; k <= 16; k++) drive(1'b1, (k > 0) ? 8'd1 : 8'd0, 1'b0);
    repeat (3) drive(1'b0, 8'd0, 1'b0);

    // Alarm, hold over empty windows, ack mid-window, ack on exceeding window end
    thr_i = 8'd5;
    e0 = edge_n + 1;
    expect_win(e0 + 16, 6, 1, 16);
    expect_win(e0 + 32, 0, 1, 16);
    expect_win(e0 + 48, 0, 1, 16);
    expect_win(e0 + 64, 6, 1, 6);
    expect_win(e0 + 80, 0, 1, 6);
    for (int k = 0; k <= 80; k++) begin
      drive(1'b1, ((k >= 1 && k <= 6) || (k >= 55 && k <= 60)) ? 8'd1 : 8'd0,
            (k == 50 || k == 64) ? 1'b1 : 1'b0);
      if (k == 49) chk("alarm_held", alarm_o, 1);
      if (k == 50) begin
        chk("alarm_after_ack", alarm_o, 0);
        chk("peak_after_ack", peak_o, 0);
      end
    end
    repeat (3) drive(1'b0, 8'd0, 1'b0);
    chk("alarm_kept_in_idle", alarm_o, 1);
    drive(1'b0, 8'd0, 1'b1);
    chk("alarm_ack_idle", alarm_o, 0);
    chk("peak_ack_idle", peak_o, 0);

    // Enable drop at win_cnt=7 for 3 cycles; re-capture 11 edges after first capture
    thr_i = 8'd200;
    e0 = edge_n + 1;
    expect_win(e0 + 27, 16, 0, 16);
    for (int k = 0; k <= 27; k++)
      drive((k >= 8 && k <= 10) ? 1'b0 : 1'b1, (k >= 1) ? 8'd1 : 8'd0, 1'b0);
    repeat (3) drive(1'b0, 8'd0, 1'b0);

    // Peak sequence 3, 9, 4
    drive(1'b0, 8'd0, 1'b1);
    e0 = edge_n + 1;
    expect_win(e0 + 16, 3, 0, 3);
    expect_win(e0 + 32, 9, 0, 9);
    expect_win(e0 + 48, 4, 0, 9);
    for (int k = 0; k <= 48; k++)
      drive(1'b1, ((k >= 1 && k <= 3) || (k >= 17 && k <= 25) || (k >= 33 && k <= 36))
                  ? 8'd1 : 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b0);
    drive(1'b0, 8'd0, 1'b1);
    chk("peak_final_ack", peak_o, 0);

    // Reset mid-window
    chk("delta_before_reset", delta_o, 4);
    repeat (5) drive(1'b1, 8'd1, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_delta", delta_o, 0);
    chk("midrst_vld", delta_vld_o, 0);
    chk("midrst_alarm", alarm_o, 0);
    repeat (2) drive(1'b1, 8'd1, 1'b0);
    rst_ni = 1'b1;
    repeat (5) drive(1'b0, 8'd0, 1'b0);

    chk("pending_expected", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
